first_down_counter: RTL
=======================

Name: first_down_counter

Overview:
- Loadable down counter with underflow detection.
- Counterpart of the 4-bit up counter with overflow flag: counts toward zero instead of toward all-ones.
- Flags the wrap from 0 as an underflow. Used as a countdown timer / terminal-count source.
- Optional auto-reload of the last loaded value turns it into a periodic tick generator.

Parameters:
- WIDTH, 4, counter width in bits (≥2).
- AUTO_RELOAD, 0. 0: decrement from 0 wraps to all-ones. 1: decrement from 0 reloads reload_reg.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; the block is in reset while reset==0
- enable  input  1  decrement request, sampled each rising edge
- load  input  1  load request, sampled each rising edge
- load_value  input  WIDTH  value captured on load
- clear_flag  input  1  clears sticky underflow_out
- counter_out  output  WIDTH  registered count
- underflow_out  output  1  sticky underflow flag, registered
- underflow_pulse  output  1  one-cycle pulse on each underflow event, registered
- zero_out  output  1  registered; 1 when counter_out==0

Behaviour:
- All state is registered. Outputs change only on a rising clk edge or on assertion of reset.
- Reset (reset==0, asynchronous):
  - counter_out=0, reload_reg=0, underflow_out=0, underflow_pulse=0, zero_out=1.
  - Release is synchronous to the next edge. The first action happens on the first rising edge with reset==1.
- Per-edge priority (reset==1):
  1. load==1: counter_out<=load_value, reload_reg<=load_value. No underflow event. enable is ignored that cycle.
  2. else enable==1 and counter_out!=0: counter_out<=counter_out-1.
  3. else enable==1 and counter_out==0: underflow event.
     - AUTO_RELOAD=0: counter_out<= all-ones.
     - AUTO_RELOAD=1: counter_out<=reload_reg.
  4. else: hold.
- reload_reg is written only by load. It holds its value across underflow events.
- zero_out is updated together with counter_out and equals (next counter_out==0). It is 1 for as long as the count sits at 0.
- underflow_pulse is 1 for exactly the cycle after an underflow event, else 0. Back-to-back events give back-to-back pulses (e.g. AUTO_RELOAD=1 with reload_reg=0 and enable held).
- underflow_out:
  - set by an underflow event; cleared by clear_flag.
  - Event and clear_flag in the same cycle: set wins (underflow_out stays/becomes 1).
  - load does not affect underflow_out.
- Latency: one clock from sampled input to visible output. No combinational input-to-output paths.
- Arithmetic: all arithmetic is modulo 2^WIDTH. No X propagation from load_value when load==0.
- Reset asserted mid-count: all outputs return to reset values immediately (asynchronously), and any pending pulse is dropped.

Test Plan (WIDTH=4):
1. Reset and load:
   - Stimulus: hold reset=0 for 3 cycles, then release; load=1, load_value=4'd5 for one cycle.
   - Required: counter_out=0, zero_out=1, flags=0 during reset; then counter_out=5, zero_out=0.
2. Countdown and wrap, AUTO_RELOAD=0:
   - Stimulus: load 3, then enable=1 for 5 cycles.
   - Required: counter_out 3,2,1,0,15,14. zero_out=1 only while 0. underflow_pulse=1 in the cycle counter_out first shows 15. underflow_out=1 thereafter.
3. Auto-reload, AUTO_RELOAD=1:
   - Stimulus: load 2, enable held for 7 cycles.
   - Required: counter_out 2,1,0,2,1,0,2,1. Two underflow_pulse cycles, each coinciding with counter_out showing 2 after 0.
4. Flag priority:
   - Stimulus: with underflow_out=1, assert clear_flag alone; later assert clear_flag in the same cycle as an underflow event.
   - Required: first case clears to 0; second case leaves underflow_out=1.
5. Load vs enable collision:
   - Stimulus: at counter_out=0, assert load=1 with load_value=9 and enable=1 together.
   - Required: counter_out=9, no underflow_pulse, underflow_out unchanged.
6. Async reset mid-operation:
   - Stimulus: enable running, underflow_out=1; drop reset between clock edges.
   - Required: counter_out=0, underflow_out=0, underflow_pulse=0, zero_out=1 before the next edge. reload_reg=0 (checked via AUTO_RELOAD=1 underflow yielding 0).

Source files
------------

// File: rtl/first_down_counter.sv
// ----------------------------------------------------------------------------
// first_down_counter
//
// Loadable down counter with underflow detection. Counts toward zero and
// flags the step taken from 0 as an underflow event. With AUTO_RELOAD=0 the
// count wraps to all-ones; with AUTO_RELOAD=1 it reloads the last loaded
// value, turning the block into a periodic tick generator.
//
// Parameters:
//   WIDTH        counter width in bits (>= 2)
//   AUTO_RELOAD  0: underflow wraps to all-ones, 1: underflow reloads
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   enable           decrement request, sampled each rising edge
//   load             load request (beats enable), sampled each rising edge
//   load_value       value captured into the count and the reload register
//   clear_flag       clears the sticky underflow flag (an event wins)
//   counter_out      registered count
//   underflow_out    sticky underflow flag, registered
//   underflow_pulse  one-cycle pulse following each underflow event
//   zero_out         registered, 1 while counter_out == 0
// ----------------------------------------------------------------------------
module first_down_counter #(
    parameter int WIDTH       = 4,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_flag,
    output logic [WIDTH-1:0] counter_out,
    output logic             underflow_out,
    output logic             underflow_pulse,
    output logic             zero_out
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             flag_q, flag_d;
    logic             pulse_q, pulse_d;
    logic             zero_q, zero_d;
    logic             uf_event;

    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        uf_event = 1'b0;

        if (load) begin
            // load_value is only looked at here, so an undriven value while
            // load==0 cannot leak into the state.
            cnt_d    = load_value;
            reload_d = load_value;
        end else if (enable) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - WIDTH'(1);
            end else begin
                uf_event = 1'b1;
                cnt_d    = (AUTO_RELOAD != 0) ? reload_q : '1;
            end
        end

        pulse_d = uf_event;
        // A new event outranks a simultaneous clear.
        flag_d  = uf_event | (flag_q & ~clear_flag);
        // Zero flag is registered alongside the count it describes.
        zero_d  = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            reload_q <= '0;
            flag_q   <= 1'b0;
            pulse_q  <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            flag_q   <= flag_d;
            pulse_q  <= pulse_d;
            zero_q   <= zero_d;
        end
    end

    assign counter_out     = cnt_q;
    assign underflow_out   = flag_q;
    assign underflow_pulse = pulse_q;
    assign zero_out        = zero_q;

endmodule
